cache_line_writeback: RTL and testbench

//  Drains one dirty cache line to memory as a burst of 32-bit write beats.

---
 rtl/cache_line_writeback_if.sv | 26 ++
 rtl/cache_line_writeback.sv | 123 ++++++++++++
 tb/tb_cache_line_writeback.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_line_writeback_if.sv
// Memory write port between the writeback engine and the memory.
// The master side presents one 32-bit write beat at a time with
// valid/ready; mem_last marks the final beat of a cache line.
interface cache_line_writeback_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_last;

    modport master (
        output mem_valid,
        output mem_addr,
        output mem_wdata,
        output mem_last,
        input  mem_ready
    );

    modport slave (
        input  mem_valid,
        input  mem_addr,
        input  mem_wdata,
        input  mem_last,
        output mem_ready
    );
endinterface

// File: rtl/cache_line_writeback.sv
// Drains one dirty cache line to memory as a burst of 32-bit write beats.
// Each word is fetched from the line's combinational data port into a
// register, then offered on the memory port until it is accepted.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for wb_start; line_offset parked at 0
//   ST_FETCH | one cycle: drive offset to the line, register its word
//   ST_SEND  | beat valid on the memory port, held until mem_ready
//   ST_DONE  | one cycle: pulse wb_done, then back to idle
//
// TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH + 2 must equal 32.
module cache_line_writeback #(
    parameter int TAG_WIDTH    = 20,
    parameter int INDEX_WIDTH  = 6,
    parameter int OFFSET_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wb_start,
    input  logic [TAG_WIDTH-1:0]    wb_tag,
    input  logic [INDEX_WIDTH-1:0]  wb_index,
    output logic                    wb_busy,
    output logic                    wb_done,
    output logic [OFFSET_WIDTH-1:0] line_offset,
    input  logic [31:0]             line_data,
    cache_line_writeback_if.master  mem
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [TAG_WIDTH-1:0]    tag_q;
    logic [INDEX_WIDTH-1:0]  index_q;
    logic [OFFSET_WIDTH-1:0] offset_q;
    logic [31:0]             wdata_q;
    logic                    last_word;

    assign last_word = (offset_q == {OFFSET_WIDTH{1'b1}});

    // State register; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; start is only honoured while idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (wb_start) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (mem.mem_ready) begin
                    state_d = last_word ? ST_DONE : ST_FETCH;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line address capture, word pointer and beat data register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_q    <= '0;
            index_q  <= '0;
            offset_q <= '0;
            wdata_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (wb_start) begin
                        tag_q    <= wb_tag;
                        index_q  <= wb_index;
                        offset_q <= '0;
                    end
                end
                ST_FETCH: begin
                    wdata_q <= line_data;
                end
                ST_SEND: begin
                    // The pointer only wraps by restarting from idle, so the
                    // final handshake leaves it at all-ones.
                    if (mem.mem_ready && !last_word) begin
                        offset_q <= offset_q + OFFSET_WIDTH'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Beat outputs depend only on registered state, never on mem_ready.
    assign line_offset   = (state_q == ST_IDLE) ? '0 : offset_q;
    assign wb_busy       = (state_q != ST_IDLE);
    assign wb_done       = (state_q == ST_DONE);
    assign mem.mem_valid = (state_q == ST_SEND);
    assign mem.mem_last  = (state_q == ST_SEND) && last_word;
    assign mem.mem_addr  = {tag_q, index_q, offset_q, 2'b00};
    assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_cache_line_writeback.sv
// Bench for cache_line_writeback: random lines and tags, random or scripted
// memory backpressure, checked against an expected-beat queue built from
// the line contents and the {tag, index, offset, 00} address rule.
module tb_cache_line_writeback;

    localparam int NW = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_start = 1'b0;
    logic [19:0] wb_tag = '0;
    logic [5:0]  wb_index = '0;
    logic        wb_busy;
    logic        wb_done;
    logic [3:0]  line_offset;
    logic [31:0] line_data;
    logic [31:0] line_mem [NW];

    cache_line_writeback_if mem_if ();

    cache_line_writeback #(
        .TAG_WIDTH    (20),
        .INDEX_WIDTH  (6),
        .OFFSET_WIDTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wb_start    (wb_start),
        .wb_tag      (wb_tag),
        .wb_index    (wb_index),
        .wb_busy     (wb_busy),
        .wb_done     (wb_done),
        .line_offset (line_offset),
        .line_data   (line_data),
        .mem         (mem_if)
    );

    always #5 clk = ~clk;

    // Cache line model: combinational word read.
    assign line_data = line_mem[line_offset];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t exp_q [$];
    beat_t b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int start_cyc  = 0;
    int beat_idx   = 0;
    int stalls     = 0;
    int stall_beat = -1;
    int stall_left = 0;
    bit rand_ready = 1'b0;

    logic        hold = 1'b0;
    logic [31:0] hold_addr;
    logic [31:0] hold_data;
    logic        hold_last;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Free-running cycle count, read only at negedges.
    always @(posedge clk) cyc <= cyc + 1;

    // Memory-side model: drives mem_ready, scores beats and done.
    always @(negedge clk) begin
        if (!rst) begin
            hold = 1'b0;
            mem_if.mem_ready = 1'b1;
        end else begin
            if (stall_left > 0 && mem_if.mem_valid && beat_idx == stall_beat) begin
                mem_if.mem_ready = 1'b0;
                stall_left--;
            end else if (rand_ready) begin
                mem_if.mem_ready = ($urandom_range(0, 3) != 0);
            end else begin
                mem_if.mem_ready = 1'b1;
            end

            if (hold) begin
                chk("hold_valid", 32'(mem_if.mem_valid), 32'd1);
                chk("hold_addr", mem_if.mem_addr, hold_addr);
                chk("hold_wdata", mem_if.mem_wdata, hold_data);
                chk("hold_last", 32'(mem_if.mem_last), 32'(hold_last));
            end
            hold = 1'b0;

            if (mem_if.mem_valid) begin
                chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
                if (mem_if.mem_ready) begin
                    if (exp_q.size() != 0) begin
                        b = exp_q.pop_front();
                        chk("beat_addr", mem_if.mem_addr, b.addr);
                        chk("beat_wdata", mem_if.mem_wdata, b.data);
                        chk("beat_last", 32'(mem_if.mem_last), 32'(b.last));
                    end
                    beat_idx++;
                end else begin
                    stalls++;
                    hold      = 1'b1;
                    hold_addr = mem_if.mem_addr;
                    hold_data = mem_if.mem_wdata;
                    hold_last = mem_if.mem_last;
                end
            end

            if (wb_done) begin
                chk("done_beats", 32'(beat_idx), 32'(NW));
                chk("done_leftover", 32'(exp_q.size()), 32'd0);
                // Counting the start cycle as cycle 1: 2 cycles per beat,
                // plus the done cycle, plus one per refused cycle.
                chk("done_latency", 32'(cyc - start_cyc + 1), 32'(2 * NW + 1 + stalls));
            end
        end
    end

    // Fill the line, queue the expected burst, and pulse wb_start.
    task automatic start_burst(input logic [19:0] tag, input logic [5:0] idx, input bit ramp);
        beat_t e;
        @(negedge clk);
        for (int i = 0; i < NW; i++) begin
            line_mem[i] = ramp ? (32'h1000 + 32'(i)) : $urandom;
            e.addr = (32'(tag) << 12) | (32'(idx) << 6) | (32'(i) << 2);
            e.data = line_mem[i];
            e.last = (i == NW - 1);
            exp_q.push_back(e);
        end
        beat_idx = 0;
        stalls   = 0;
        wb_start = 1'b1;
        wb_tag   = tag;
        wb_index = idx;
        @(negedge clk);
        start_cyc = cyc;
        wb_start  = 1'b0;
        chk("busy_after_start", 32'(wb_busy), 32'd1);
        wb_tag   = 20'($urandom);
        wb_index = 6'($urandom);
    endtask

    task automatic wait_done(input int bound);
        bit seen = 1'b0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (wb_done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic idle_window(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("idle_valid", 32'(mem_if.mem_valid), 32'd0);
            chk("idle_busy", 32'(wb_busy), 32'd0);
            chk("idle_done", 32'(wb_done), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [19:0] t;
        logic [5:0]  x;
        bit          reached;

        for (int i = 0; i < NW; i++) line_mem[i] = '0;
        repeat (3) @(negedge clk);

        chk("rst_busy", 32'(wb_busy), 32'd0);
        chk("rst_done", 32'(wb_done), 32'd0);
        chk("rst_valid", 32'(mem_if.mem_valid), 32'd0);
        chk("rst_last", 32'(mem_if.mem_last), 32'd0);
        chk("rst_wdata", mem_if.mem_wdata, 32'd0);
        chk("rst_addr", mem_if.mem_addr, 32'd0);
        chk("rst_offset", 32'(line_offset), 32'd0);
        rst = 1'b1;
        idle_window(2);

        // Full burst, memory always ready.
        start_burst(20'hABCDE, 6'h15, 1'b1);
        wait_done(200);
        idle_window(3);

        // Five refused cycles on beat 3.
        stall_beat = 3;
        stall_left = 5;
        start_burst(20'($urandom), 6'($urandom), 1'b0);
        wait_done(200);
        chk("stall_cycles", 32'(stalls), 32'd5);
        stall_beat = -1;
        idle_window(2);

        // Start pulse with a new tag while busy at beat 7 is ignored.
        t = 20'($urandom);
        x = 6'($urandom);
        start_burst(t, x, 1'b0);
        reached = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (beat_idx >= 7) begin
                reached = 1'b1;
                break;
            end
        end
        chk("reach_beat7", 32'(reached), 32'd1);
        wb_start = 1'b1;
        wb_tag   = ~t;
        wb_index = ~x;
        @(negedge clk);
        wb_start = 1'b0;
        wait_done(200);
        idle_window(6);

        // Back-to-back: second start in the idle cycle right after done.
        start_burst(20'($urandom), 6'($urandom), 1'b0);
        wait_done(200);
        start_burst(20'($urandom), 6'($urandom), 1'b0);
        wait_done(200);
        idle_window(2);

        // Random bursts under random backpressure.
        rand_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            start_burst(20'($urandom), 6'($urandom), 1'b0);
            wait_done(400);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        rand_ready = 1'b0;
        idle_window(2);

        // Reset in the middle of a burst.
        start_burst(20'($urandom), 6'($urandom), 1'b0);
        reached = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (beat_idx >= 2 && mem_if.mem_valid) begin
                reached = 1'b1;
                break;
            end
        end
        chk("reach_send", 32'(reached), 32'd1);
        rst = 1'b0;
        #1;
        chk("midrst_valid", 32'(mem_if.mem_valid), 32'd0);
        chk("midrst_busy", 32'(wb_busy), 32'd0);
        chk("midrst_done", 32'(wb_done), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        idle_window(10);

        // Recovery burst after reset.
        start_burst(20'($urandom), 6'($urandom), 1'b0);
        wait_done(200);
        idle_window(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
